// File: rtl/down_counter_timer_if.sv
// Control/status bundle for the down counter timer.
interface down_counter_timer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             done;
    logic             expired;

    modport master (
        output start, value, enable, auto_reload,
        input  Q, busy, done, expired
    );

    modport slave (
        input  start, value, enable, auto_reload,
        output Q, busy, done, expired
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down counter / countdown timer with expiry flag and optional auto-reload.
module down_counter_timer #(
    parameter int unsigned WIDTH = 16
) (
    input logic                 clock,
    input logic                 clear,
    down_counter_timer_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_EXPIRED = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] reload_q,  reload_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             expired_q, expired_d;

    logic             dec_c;
    logic [WIDTH-1:0] cnt_dec_c;

    // Decrement request: only ticks in RUN that are not overridden by a load, never below 0.
    assign dec_c = (state_q == ST_RUN) && bus.enable && !bus.start && (cnt_q != '0);

    // Borrow chain: bit i toggles when decrementing and all lower bits are 0.
    always_comb begin : borrow_chain
        logic borrow;
        borrow    = dec_c;
        cnt_dec_c = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_dec_c[i] = cnt_q[i] ^ borrow;
            borrow       = borrow & ~cnt_q[i];
        end
    end

    // Next-state, next-count and registered output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (bus.start) begin
            // Load from any state; a zero load expires immediately.
            cnt_d    = bus.value;
            reload_d = bus.value;
            if (bus.value != '0) begin
                state_d = ST_RUN;
            end else begin
                done_d  = 1'b1;
                state_d = ST_EXPIRED;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.enable && (cnt_q == WIDTH'(1))) begin
                        // Expiry edge: reload skips the zero count entirely.
                        done_d = 1'b1;
                        if (bus.auto_reload) begin
                            cnt_d = reload_q;
                        end else begin
                            cnt_d   = '0;
                            state_d = ST_EXPIRED;
                        end
                    end else begin
                        cnt_d = cnt_dec_c;
                    end
                end
                ST_EXPIRED: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d    = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            reload_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    assign bus.Q       = cnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer.
module tb_down_counter_timer;

    localparam int unsigned WIDTH = 16;

    logic clock;
    logic clear;
    int   n_checks;
    int   n_errors;

    down_counter_timer_if #(.WIDTH(WIDTH)) dut_if ();

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (dut_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        dut_if.start = 1'b1;
        dut_if.value = 16'd5;
        dut_if.enable = 1'b1;
        tick();
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd0, 3'b000}) begin
            n_errors++;
            $display("FAIL reset: Q=%h b/d/e=%b%b%b required Q=0000 b/d/e=000",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        clear = 1'b0;
        dut_if.start = 1'b0;
        tick();
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd0, 3'b000}) begin
            n_errors++;
            $display("FAIL idle_hold: Q=%h b/d/e=%b%b%b required Q=0000 b/d/e=000",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        dut_if.enable = 1'b0;
    endtask

    task automatic test_count_expiry();
        logic [15:0] exp_q;
        logic [2:0]  exp_f;
        dut_if.auto_reload = 1'b0;
        dut_if.start = 1'b1;
        dut_if.value = 16'd3;
        dut_if.enable = 1'b1;
        tick();
        dut_if.start = 1'b0;
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd3, 3'b100}) begin
            n_errors++;
            $display("FAIL count_load: Q=%h b/d/e=%b%b%b required Q=0003 b/d/e=100",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_q = 16'(2 - i);
            exp_f = (i == 2) ? 3'b011 : 3'b100;
            n_checks++;
            if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {exp_q, exp_f}) begin
                n_errors++;
                $display("FAIL count_step%0d: Q=%h b/d/e=%b%b%b required Q=%h b/d/e=%b",
                         i, dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired, exp_q, exp_f);
            end
        end
        tick();
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd0, 3'b001}) begin
            n_errors++;
            $display("FAIL done_one_cycle: Q=%h b/d/e=%b%b%b required Q=0000 b/d/e=001",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        dut_if.enable = 1'b0;
    endtask

    task automatic test_borrow();
        logic [15:0] exp_q;
        dut_if.start = 1'b1;
        dut_if.value = 16'h0100;
        dut_if.enable = 1'b0;
        tick();
        dut_if.start = 1'b0;
        exp_q = 16'h0100;
        n_checks++;
        if (dut_if.Q !== exp_q) begin
            n_errors++;
            $display("FAIL borrow_load: Q=%h required %h", dut_if.Q, exp_q);
        end
        for (int i = 0; i < 8; i++) begin
            dut_if.enable = (i % 2 == 0);
            tick();
            if (i % 2 == 0) exp_q = exp_q - 16'd1;
            n_checks++;
            if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {exp_q, 3'b100}) begin
                n_errors++;
                $display("FAIL borrow_step%0d: Q=%h b/d/e=%b%b%b required Q=%h b/d/e=100",
                         i, dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired, exp_q);
            end
        end
        dut_if.enable = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [15:0] exp_q;
        logic [2:0]  exp_f;
        dut_if.auto_reload = 1'b1;
        dut_if.start = 1'b1;
        dut_if.value = 16'd2;
        dut_if.enable = 1'b1;
        tick();
        dut_if.start = 1'b0;
        dut_if.value = 16'd5;
        n_checks++;
        if (dut_if.Q !== 16'd2) begin
            n_errors++;
            $display("FAIL reload_load: Q=%h required 0002", dut_if.Q);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_q = (i % 2 == 0) ? 16'd1 : 16'd2;
            exp_f = (i % 2 == 0) ? 3'b100 : 3'b110;
            n_checks++;
            if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {exp_q, exp_f}) begin
                n_errors++;
                $display("FAIL reload_step%0d: Q=%h b/d/e=%b%b%b required Q=%h b/d/e=%b",
                         i, dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired, exp_q, exp_f);
            end
        end
        dut_if.auto_reload = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd0, 3'b011}) begin
            n_errors++;
            $display("FAIL reload_stop: Q=%h b/d/e=%b%b%b required Q=0000 b/d/e=011",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        dut_if.enable = 1'b0;
    endtask

    task automatic test_restart();
        logic [15:0] exp_q;
        logic [2:0]  exp_f;
        dut_if.auto_reload = 1'b0;
        dut_if.start = 1'b1;
        dut_if.value = 16'd10;
        dut_if.enable = 1'b1;
        tick();
        dut_if.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_q = 16'(9 - i);
            n_checks++;
            if ({dut_if.Q, dut_if.done} !== {exp_q, 1'b0}) begin
                n_errors++;
                $display("FAIL restart_pre%0d: Q=%h done=%b required Q=%h done=0",
                         i, dut_if.Q, dut_if.done, exp_q);
            end
        end
        dut_if.start = 1'b1;
        dut_if.value = 16'd7;
        tick();
        dut_if.start = 1'b0;
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd7, 3'b100}) begin
            n_errors++;
            $display("FAIL restart_load: Q=%h b/d/e=%b%b%b required Q=0007 b/d/e=100",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_q = 16'(6 - i);
            exp_f = (i == 6) ? 3'b011 : 3'b100;
            n_checks++;
            if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {exp_q, exp_f}) begin
                n_errors++;
                $display("FAIL restart_step%0d: Q=%h b/d/e=%b%b%b required Q=%h b/d/e=%b",
                         i, dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired, exp_q, exp_f);
            end
        end
        dut_if.enable = 1'b0;
    endtask

    task automatic test_zero_and_abort();
        dut_if.start = 1'b1;
        dut_if.value = 16'd0;
        dut_if.enable = 1'b0;
        tick();
        dut_if.start = 1'b0;
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd0, 3'b011}) begin
            n_errors++;
            $display("FAIL zero_load: Q=%h b/d/e=%b%b%b required Q=0000 b/d/e=011",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        dut_if.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd0, 3'b001}) begin
                n_errors++;
                $display("FAIL zero_hold%0d: Q=%h b/d/e=%b%b%b required Q=0000 b/d/e=001",
                         i, dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
            end
        end
        dut_if.start = 1'b1;
        dut_if.value = 16'd20;
        tick();
        dut_if.start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd9, 3'b100}) begin
            n_errors++;
            $display("FAIL abort_pre: Q=%h b/d/e=%b%b%b required Q=0009 b/d/e=100",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd0, 3'b000}) begin
            n_errors++;
            $display("FAIL abort_clear: Q=%h b/d/e=%b%b%b required Q=0000 b/d/e=000",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        tick();
        n_checks++;
        if ({dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired} !== {16'd0, 3'b000}) begin
            n_errors++;
            $display("FAIL abort_idle: Q=%h b/d/e=%b%b%b required Q=0000 b/d/e=000",
                     dut_if.Q, dut_if.busy, dut_if.done, dut_if.expired);
        end
        dut_if.enable = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear = 1'b0;
        dut_if.start = 1'b0;
        dut_if.value = '0;
        dut_if.enable = 1'b0;
        dut_if.auto_reload = 1'b0;
        test_reset();
        test_count_expiry();
        test_borrow();
        test_auto_reload();
        test_restart();
        test_zero_and_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
